// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start 0, DATA_BITS data LSB first, stop 1).
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   baud_tick_os      one-clk pulse, OVERSAMPLE pulses per bit period
//   rx_in             asynchronous serial line, idle high
//   rx_data           last good received word, LSB = first data bit
//   rx_valid          one-clk pulse, rx_data updated with a good frame
//   rx_frame_err      one-clk pulse, stop bit sampled low
//   rx_busy           high whenever the receiver is not idle
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick_os,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync2_q;
  logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_frame_err_q, rx_frame_err_d;
  logic                   rx_busy_q, rx_busy_d;
  logic                   rx_s;

  assign rx_s = sync2_q;

  // Next-state and output logic.
  always_comb begin
    state_d        = state_q;
    tick_cnt_d     = tick_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d    = S_START;
          tick_cnt_d = '0;
        end
      end

      S_START: begin
        if (baud_tick_os) begin
          // This tick brings the counter to OVERSAMPLE/2-1: middle of the start bit.
          if (tick_cnt_q == TICK_W'(OVERSAMPLE / 2 - 2)) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

      S_DATA: begin
        if (baud_tick_os) begin
          if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
              state_d = S_STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

      S_STOP: begin
        if (baud_tick_os) begin
          if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
            tick_cnt_d = '0;
            if (rx_s) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              state_d    = S_IDLE;
            end else begin
              rx_frame_err_d = 1'b1;
              state_d        = S_BREAK_WAIT;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end

      S_BREAK_WAIT: begin
        // A line held low after a bad stop bit must not look like a new start bit.
        if (rx_s) begin
          state_d    = S_IDLE;
          tick_cnt_d = '0;
        end
      end

      default: begin
        state_d    = S_IDLE;
        tick_cnt_d = '0;
      end
    endcase

    rx_busy_d = (state_d != S_IDLE);
  end

  // State, synchronizer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      tick_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_busy_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= rx_in;
      sync2_q        <= sync1_q;
      tick_cnt_q     <= tick_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
      rx_busy_q      <= rx_busy_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_busy      = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level model.
module tb_uart_rx;

  localparam int unsigned OS      = 16;
  localparam int unsigned DB      = 8;
  localparam int unsigned BIT_CLK = 64;  // one tick every 4 clk, 16 ticks per bit

  logic          clk = 1'b0;
  logic          rst_n;
  logic          baud_tick_os;
  logic          rx_in;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_frame_err;
  logic          rx_busy;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud_tick_os (baud_tick_os),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed and expected events: {is_error, rx_data at the pulse}.
  logic [8:0]    got_q[$];
  logic [8:0]    exp_q[$];
  logic [DB-1:0] last_good = '0;
  int            busy_cnt  = 0;
  logic          prev_valid = 1'b0;
  logic          prev_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Baud tick: one clk high out of every four.
  initial begin
    baud_tick_os = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud_tick_os = 1'b1;
      @(negedge clk);
      baud_tick_os = 1'b0;
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (rx_busy) busy_cnt++;
    if (rx_valid) begin
      check("valid_not_with_err", 32'(rx_frame_err), 32'd0);
      check("valid_one_clk", 32'(prev_valid), 32'd0);
      got_q.push_back({1'b0, rx_data});
    end
    if (rx_frame_err) begin
      check("err_one_clk", 32'(prev_err), 32'd0);
      got_q.push_back({1'b1, rx_data});
    end
    prev_valid = rx_valid;
    prev_err   = rx_frame_err;
  end

  task automatic drive(input logic v, input int clks);
    rx_in = v;
    repeat (clks) @(negedge clk);
  endtask

  // Send one frame bit-by-bit and record what a correct receiver must report.
  task automatic send_frame(input logic [DB-1:0] b, input logic stop_ok);
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < DB; i++) drive(b[i], BIT_CLK);
    drive(stop_ok, BIT_CLK);
    if (stop_ok) begin
      exp_q.push_back({1'b0, b});
      last_good = b;
    end else begin
      exp_q.push_back({1'b1, last_good});
    end
  endtask

  task automatic wait_tick();
    @(posedge clk);
    while (!baud_tick_os) @(posedge clk);
    #1;
  endtask

  // Minimal transmitter paced purely by the shared tick (16 ticks per bit).
  task automatic tx_loop(input logic [DB-1:0] b);
    logic [DB+1:0] frame;
    frame = {1'b1, b, 1'b0};
    wait_tick();
    for (int i = 0; i < DB + 2; i++) begin
      rx_in = frame[i];
      repeat (OS) wait_tick();
    end
    exp_q.push_back({1'b0, b});
    last_good = b;
  endtask

  // Wait (bounded) for the expected events, then compare them in order.
  task automatic flush(input string tag);
    int n;
    for (int i = 0; i < 800 && got_q.size() < exp_q.size(); i++) @(negedge clk);
    repeat (8) @(negedge clk);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_event"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    check({tag, "_data_hold"}, 32'(rx_data), 32'(last_good));
    check({tag, "_busy_idle"}, 32'(rx_busy), 32'd0);
  endtask

  initial begin
    int snap;
    int gap;
    logic [DB-1:0] b;
    logic ok;

    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_err", 32'(rx_frame_err), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, BIT_CLK);

    // Single good frame.
    send_frame(8'hA5, 1'b1);
    drive(1'b1, BIT_CLK);
    flush("a5");

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive(1'b1, BIT_CLK);
    flush("b2b");

    // Short low glitch: busy rises and falls, nothing reported.
    snap = busy_cnt;
    drive(1'b0, 12);
    drive(1'b1, BIT_CLK);
    check("glitch_busy_seen", 32'(busy_cnt > snap), 32'd1);
    flush("glitch");

    // Framing error followed by a held-low break, then a good frame.
    send_frame(8'h3C, 1'b0);
    drive(1'b0, 2 * BIT_CLK);
    check("break_busy", 32'(rx_busy), 32'd1);
    drive(1'b1, 8);
    check("break_release", 32'(rx_busy), 32'd0);
    drive(1'b1, BIT_CLK);
    send_frame(8'h81, 1'b1);
    drive(1'b1, BIT_CLK);
    flush("ferr");

    // Reset in the middle of data bit 4 of 0x5A aborts the frame.
    b = 8'h5A;
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive(b[i], BIT_CLK);
    drive(b[4], BIT_CLK / 2);
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_data", 32'(rx_data), 32'd0);
    check("midrst_busy", 32'(rx_busy), 32'd0);
    rst_n = 1'b1;
    last_good = '0;
    drive(1'b1, BIT_CLK);
    send_frame(8'hC3, 1'b1);
    drive(1'b1, BIT_CLK);
    flush("midrst");

    // Tick-paced transmitter looped into the receiver.
    tx_loop(8'h5A);
    tx_loop(8'h01);
    tx_loop(8'h80);
    @(negedge clk);
    drive(1'b1, BIT_CLK);
    flush("loop");

    // Randomized frames, stop errors, gaps and glitches.
    for (int k = 0; k < 24; k++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok);
      gap = ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      drive(1'b1, gap * BIT_CLK);
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 4 * int'($urandom_range(1, 5)));
        drive(1'b1, BIT_CLK);
      end
    end
    drive(1'b1, BIT_CLK);
    flush("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
